// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter encodings, defaults and line levels
//
// Purpose: state encoding for the transmit FSM, default frame geometry and the
// serial line levels used by every UART block in the slice.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant logic
//
// Purpose: picks one of two requesters; when both are valid the one that was
// not served most recently wins.
// Ports:
//   valid  [1:0] in   request lines, bit N = requester N
//   enable       in   grants are only issued while high
//   last         in   index of the requester served most recently
//   grant  [1:0] out  one-hot grant (all zero when disabled or no request)
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
        grant = last ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester UART transmitter with round-robin arbitration
//
// Purpose: accepts bytes from two valid/ready requesters, arbitrates round-robin,
// and shifts each byte out as start + DATA_BITS (LSB first) + stop, with every
// serial bit lasting OVERSAMPLE external baud_tick pulses.
// Ports:
//   clk, rst                 in   clock; synchronous active-high reset
//   baud_tick                in   oversampling tick from the shared baud generator
//   req0_valid/data/ready    requester 0 handshake (ready is combinational)
//   req1_valid/data/ready    requester 1 handshake (ready is combinational)
//   tx                       out  serial line, idle high
//   tx_busy                  out  high while a frame is in flight
//   grant_id                 out  requester index of the last accepted byte
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 grant_id
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_e          state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 grant_id_q, grant_id_d;
  logic                 last_q, last_d;

  logic [1:0] grant;
  logic       arb_en;
  logic       bit_end;

  // Ready is only offered from IDLE and never while reset is asserted.
  assign arb_en = (state_q == ST_IDLE) && !rst;

  rr_arbiter2 u_rr_arbiter2 (
    .valid  ({req1_valid, req0_valid}),
    .enable (arb_en),
    .last   (last_q),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // The OVERSAMPLE-th tick counted in the current bit closes that bit.
  assign bit_end = baud_tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;

    case (state_q)
      ST_IDLE: begin
        // Ticks seen here, including in the transfer cycle, are not counted.
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        tx_d       = IDLE_LEVEL;
        if (grant[0]) begin
          shift_d    = req0_data;
          grant_id_d = 1'b0;
          last_d     = 1'b0;
          state_d    = ST_START;
          tx_d       = START_LEVEL;
        end else if (grant[1]) begin
          shift_d    = req1_data;
          grant_id_d = 1'b1;
          last_d     = 1'b1;
          state_d    = ST_START;
          tx_d       = START_LEVEL;
        end
      end

      ST_START: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          state_d    = ST_DATA;
          tx_d       = shift_q[0];
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = ST_STOP;
            tx_d      = STOP_LEVEL;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            tx_d      = shift_d[0];
          end
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          state_d    = ST_IDLE;
          tx_d       = IDLE_LEVEL;
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= IDLE_LEVEL;
      grant_id_q <= 1'b0;
      // Pretend requester 1 was served last so requester 0 wins first contention.
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = (state_q != ST_IDLE);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int OS          = 8;
  localparam int DB          = 8;
  localparam int FRAME_TICKS = (DB + 2) * OS;

  logic          clk = 1'b0;
  logic          rst;
  logic          baud_tick;
  logic          req0_valid, req1_valid;
  logic [DB-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          tx, tx_busy, grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit tick_periodic = 1'b1;

  // Transaction-level model: a frame is FRAME_TICKS counted ticks long; the
  // serial bit on the line is simply (ticks counted so far) / OS.
  bit            m_busy  = 1'b0;
  int            m_n     = 0;
  logic [DB-1:0] m_byte  = '0;
  bit            m_grant = 1'b0;
  bit            m_last  = 1'b1;
  bit            m_r0    = 1'b0;
  bit            m_r1    = 1'b0;

  bit   rec = 1'b0;
  logic q_tx[$];
  int   acc_log[$];
  int   gaps[$];
  int   idle_run  = 0;
  bit   seen_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_tx();
    int b;
    if (!m_busy) return 1'b1;
    b = m_n / OS;
    if (b == 0) return 1'b0;
    if (b <= DB) return m_byte[b-1];
    return 1'b1;
  endfunction

  function automatic int winner();
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic step();
    int w;
    @(negedge clk);
    w    = (rst || m_busy) ? -1 : winner();
    m_r0 = (w == 0);
    m_r1 = (w == 1);
    chk("req0_ready", req0_ready, m_r0);
    chk("req1_ready", req1_ready, m_r1);
    chk("tx", tx, exp_tx());
    chk("tx_busy", tx_busy, m_busy);
    chk("grant_id", grant_id, m_grant);
    if (req0_ready) acc_log.push_back(0);
    if (req1_ready) acc_log.push_back(1);
    if (rec && tx_busy) q_tx.push_back(tx);
    if (tx_busy) begin
      if (seen_busy && idle_run > 0) gaps.push_back(idle_run);
      seen_busy = 1'b1;
      idle_run  = 0;
    end else begin
      idle_run++;
    end
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_n = 0; m_byte = '0; m_grant = 1'b0; m_last = 1'b1;
    end else if (m_busy) begin
      if (baud_tick) begin
        m_n++;
        if (m_n == FRAME_TICKS) m_busy = 1'b0;
      end
    end else if (w >= 0) begin
      m_busy  = 1'b1;
      m_n     = 0;
      m_byte  = (w == 1) ? req1_data : req0_data;
      m_grant = w[0];
      m_last  = w[0];
    end
    #1;
    cyc++;
    baud_tick = tick_periodic ? (cyc % 4 == 0) : ($urandom_range(0, 1) == 0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic hold_until_accept(input int who, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = (who == 1) ? m_r1 : m_r0;
    end
    chk("accept_timeout", ok, 1'b1);
    if (who == 1) req1_valid = 1'b0;
    else          req0_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((m_busy || tx_busy) && i < budget) begin
      step();
      i++;
    end
    chk("idle_timeout", (m_busy || tx_busy), 1'b0);
  endtask

  task automatic serve_both(input int budget);
    int i = 0;
    while ((req0_valid || req1_valid) && i < budget) begin
      step();
      if (m_r0) req0_valid = 1'b0;
      if (m_r1) req1_valid = 1'b0;
      i++;
    end
    chk("serve_timeout", (req0_valid || req1_valid), 1'b0);
  endtask

  initial begin
    int       start_len;
    int       n_acc;
    int       g0, g1;
    int       idx;
    logic [9:0] a5_bits;

    rst = 1'b1; baud_tick = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h11; req1_data = 8'h22;
    @(posedge clk); #1;
    run(3);
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    run(2);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_grant", grant_id, 1'b0);

    // Single 0xA5 frame from requester 0.
    q_tx.delete(); acc_log.delete(); rec = 1'b1;
    req0_data = 8'hA5; req0_valid = 1'b1;
    hold_until_accept(0, 10);
    wait_idle(1000);
    rec = 1'b0;
    chk("a5_ready_pulses", acc_log.size(), 1);
    chk("a5_grant", grant_id, 1'b0);
    start_len = 0;
    while (start_len < q_tx.size() && q_tx[start_len] == 1'b0) start_len++;
    chk("a5_start_len_in_range", (start_len >= 29 && start_len <= 32), 1'b1);
    chk("a5_busy_len", q_tx.size(), start_len + 9 * 32);
    a5_bits = 10'b1101001010;
    for (int k = 1; k < 10; k++) begin
      idx = start_len + 32 * (k - 1) + 16;
      chk($sformatf("a5_bit%0d", k), (idx < q_tx.size()) ? q_tx[idx] : 1'bx, a5_bits[k]);
    end

    // Contention right after reset, then a second contention.
    rst = 1'b1; run(1); rst = 1'b0;
    acc_log.delete();
    req0_data = 8'h55; req1_data = 8'h0F;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve_both(3000);
    wait_idle(1000);
    chk("rr_first", (acc_log.size() > 0) ? acc_log[0] : -1, 0);
    chk("rr_second", (acc_log.size() > 1) ? acc_log[1] : -1, 1);
    chk("rr_grant_after", grant_id, 1'b1);
    gaps.delete(); seen_busy = 1'b0; acc_log.delete();
    req0_data = 8'h33; req1_data = 8'h44;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve_both(3000);
    wait_idle(1000);
    chk("rr_next_contention", (acc_log.size() > 0) ? acc_log[0] : -1, 0);
    chk("waiting_req_gap", (gaps.size() > 0) ? gaps[0] : -1, 1);

    // Reset during DATA bit 3 aborts the frame, then a req1-only frame.
    req0_data = 8'h3C; req0_valid = 1'b1;
    hold_until_accept(0, 10);
    run(140);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    req1_data = 8'hC3; req1_valid = 1'b1;
    hold_until_accept(1, 10);
    wait_idle(1000);
    chk("after_abort_grant", grant_id, 1'b1);

    // Requester 0 held valid for three bytes back to back.
    gaps.delete(); seen_busy = 1'b0; acc_log.delete();
    req0_data = 8'h81; req0_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 3000 && n_acc < 3; i++) begin
      step();
      if (m_r0) begin
        n_acc++;
        if (n_acc == 1) req0_data = 8'h42;
        if (n_acc == 2) req0_data = 8'h24;
        if (n_acc == 3) req0_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    wait_idle(1000);
    g0 = (gaps.size() > 0) ? gaps[0] : -1;
    g1 = (gaps.size() > 1) ? gaps[1] : -1;
    chk("b2b_frames", acc_log.size(), 3);
    chk("b2b_gap0", g0, 1);
    chk("b2b_gap1", g1, 1);

    // Random traffic, random ticks, rare resets.
    tick_periodic = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      if (m_r0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 7) == 0);
        req0_data  = 8'($urandom);
      end else if ($urandom_range(0, 40) == 0) begin
        req0_valid = 1'b0;
      end
      if (m_r1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 7) == 0);
        req1_data  = 8'($urandom);
      end else if ($urandom_range(0, 40) == 0) begin
        req1_valid = 1'b0;
      end
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
